// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the instruction ROM and registers
// fetched words into a one-entry valid/ready stage. Optional J predecode: FETCH_J_PREDECODE_EN.
module inst_fetch_ctrl #(
    parameter int PC_W   = 5,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   pc_o,
    input  logic [INST_W-1:0] inst_i,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [INST_W-1:0] if_inst,
    output logic [PC_W-1:0]   if_pc,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              halt_req,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALTED
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W-1:0]     seq_pc, next_pc;
    logic                valid_q, valid_d;
    logic [INST_W-1:0]   inst_q;
    logic [PC_W-1:0]     ipc_q;
    logic                free;
    logic                load;

    assign free   = !valid_q || if_ready;
    assign seq_pc = pc_q + PC_ONE;   // wraps modulo 2^PC_W by width

`ifdef FETCH_J_PREDECODE_EN
    // A J word redirects fetch at the fetch itself, so the target follows with no bubble.
    assign next_pc = (inst_i[31:26] == 6'b000010) ? inst_i[PC_W-1:0] : seq_pc;
`else
    assign next_pc = seq_pc;
`endif

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q && !if_ready;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = RUN;
                if (redirect_valid) pc_d = redirect_pc;
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    state_d = halt_req ? DRAIN : RUN;
                end else if (halt_req) begin
                    state_d = DRAIN;
                end else if (free) begin
                    load    = 1'b1;
                    valid_d = 1'b1;
                    pc_d    = next_pc;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    state_d = halt_req ? DRAIN : RUN;
                end else if (free) begin
                    valid_d = 1'b0;
                    state_d = HALTED;
                end
            end
            HALTED: begin
                valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = halt_req ? DRAIN : RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            valid_q <= 1'b0;
            inst_q  <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            if (load) begin
                inst_q <= inst_i;
                ipc_q  <= pc_q;
            end
        end
    end

    assign pc_o     = pc_q;
    assign if_valid = valid_q;
    assign if_inst  = inst_q;
    assign if_pc    = ipc_q;
    assign halted   = (state_q == HALTED);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: sequential fetch with wrap, stall, redirect,
// halt, J predecode (build-dependent) and mid-stream reset.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  pc_o;
    logic [31:0] inst_i;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [4:0]  if_pc;
    logic        redirect_valid;
    logic [4:0]  redirect_pc;
    logic        halt_req;
    logic        halted;

    logic [31:0] rom [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    localparam logic [31:0] J8 = {6'b000010, 26'd8};

    inst_fetch_ctrl #(.PC_W(5), .INST_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_o           (pc_o),
        .inst_i         (inst_i),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    assign inst_i = rom[pc_o];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [4:0] pc, input logic [31:0] inst);
        check({tag, ".valid"}, 32'(if_valid), 32'd1);
        check({tag, ".pc"},    32'(if_pc),    32'(pc));
        check({tag, ".inst"},  if_inst,       inst);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'(i);
        rst = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
        step(); step();
        check("rst.valid",  32'(if_valid), 32'd0);
        check("rst.pc_o",   32'(pc_o),     32'd0);
        check("rst.inst",   if_inst,       32'd0);
        check("rst.if_pc",  32'(if_pc),    32'd0);
        check("rst.halted", 32'(halted),   32'd0);

        // Release: first edge IDLE->RUN, second edge fetches word 0
        rst = 1'b0;
        step();
        check("idle.valid", 32'(if_valid), 32'd0);
        step();
        check_word("fetch0", 5'd0, 32'd0);
        check("fetch0.pc_o", 32'(pc_o), 32'd1);
        for (int k = 1; k < 32; k++) begin
            step();
            check_word("seq", 5'(k), 32'(k));
        end
        step();
        check_word("wrap", 5'd0, 32'd0);
        for (int k = 1; k <= 4; k++) step();
        check_word("pre_stall", 5'd4, 32'd4);

        // Backpressure: 3 stalled cycles at if_pc=4
        if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_word("stall", 5'd4, 32'd4);
            check("stall.pc_o", 32'(pc_o), 32'd5);
        end
        if_ready = 1'b1;
        step();
        check_word("resume5", 5'd5, 32'd5);
        step();
        check_word("resume6", 5'd6, 32'd6);

        // Redirect to 8 while a word is held under backpressure
        if_ready = 1'b0;
        step();
        check_word("hold6", 5'd6, 32'd6);
        redirect_valid = 1'b1; redirect_pc = 5'd8;
        step();
        check("redir.valid", 32'(if_valid), 32'd0);
        check("redir.pc_o",  32'(pc_o),     32'd8);
        redirect_valid = 1'b0; if_ready = 1'b1;
        step();
        check_word("redir8", 5'd8, 32'd8);
        step();
        check_word("redir9", 5'd9, 32'd9);

        // Halt with pc_q=3 and the held word not yet accepted
        redirect_valid = 1'b1; redirect_pc = 5'd2;
        step();
        redirect_valid = 1'b0;
        step();
        check_word("pre_halt", 5'd2, 32'd2);
        check("pre_halt.pc_o", 32'(pc_o), 32'd3);
        halt_req = 1'b1; if_ready = 1'b0;
        step();
        check_word("drain1", 5'd2, 32'd2);
        check("drain1.halted", 32'(halted), 32'd0);
        halt_req = 1'b0;
        step();
        check_word("drain2", 5'd2, 32'd2);
        check("drain2.halted", 32'(halted), 32'd0);
        if_ready = 1'b1;
        step();
        check("halt.halted", 32'(halted),   32'd1);
        check("halt.valid",  32'(if_valid), 32'd0);
        check("halt.pc_o",   32'(pc_o),     32'd3);
        step();
        check("halt2.halted", 32'(halted), 32'd1);
        check("halt2.pc_o",   32'(pc_o),   32'd3);
        redirect_valid = 1'b1; redirect_pc = 5'd0;
        step();
        check("unhalt.halted", 32'(halted),   32'd0);
        check("unhalt.valid",  32'(if_valid), 32'd0);
        check("unhalt.pc_o",   32'(pc_o),     32'd0);
        redirect_valid = 1'b0;
        step();
        check_word("unhalt0", 5'd0, 32'd0);

        // Halt and redirect in the same RUN cycle: redirect applied, then DRAIN
        halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 5'd20;
        step();
        check("hr.pc_o",   32'(pc_o),     32'd20);
        check("hr.valid",  32'(if_valid), 32'd0);
        check("hr.halted", 32'(halted),   32'd0);
        halt_req = 1'b0; redirect_valid = 1'b0;
        step();
        check("hr2.halted", 32'(halted), 32'd1);
        check("hr2.pc_o",   32'(pc_o),   32'd20);

        // J at ROM[0xC]
        rom[12] = J8;
        redirect_valid = 1'b1; redirect_pc = 5'd10;
        step();
        check("j.halted", 32'(halted), 32'd0);
        redirect_valid = 1'b0;
        step();
        check_word("j10", 5'd10, 32'd10);
        step();
        check_word("j11", 5'd11, 32'd11);
        step();
        check_word("j12", 5'd12, J8);
`ifdef FETCH_J_PREDECODE_EN
        check("j12.pc_o", 32'(pc_o), 32'd8);
        step();
        check_word("j_tgt8", 5'd8, 32'd8);
        step();
        check_word("j_tgt9", 5'd9, 32'd9);
`else
        check("j12.pc_o", 32'(pc_o), 32'd13);
        step();
        check_word("j_seq13", 5'd13, 32'd13);
`endif

        // Reset mid-stream at if_pc=6
        redirect_valid = 1'b1; redirect_pc = 5'd5;
        step();
        redirect_valid = 1'b0;
        step();
        check_word("mid5", 5'd5, 32'd5);
        step();
        check_word("mid6", 5'd6, 32'd6);
        rst = 1'b1;
        step();
        check("mrst.valid",  32'(if_valid), 32'd0);
        check("mrst.pc_o",   32'(pc_o),     32'd0);
        check("mrst.halted", 32'(halted),   32'd0);
        check("mrst.if_pc",  32'(if_pc),    32'd0);
        rst = 1'b0;
        step();
        check("mrst_idle.valid", 32'(if_valid), 32'd0);
        step();
        check_word("mrst_fetch0", 5'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
